// File: rtl/mem_stage.sv
// MEM pipeline stage: word-addressed data RAM with MEM_LATENCY-cycle accesses feeding MEM/WB.
// Define MEM_ALIGN_CHECK_EN to suppress misaligned requests and flag them on AlignErr.
module mem_stage #(
  parameter int MEM_DEPTH   = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [1:0]  MEMControl,
  input  logic [1:0]  WBControl,
  input  logic [4:0]  RdIn,
  output logic        Stall,
  output logic [31:0] ReadDataOut,
  output logic [31:0] ResultOut,
  output logic [1:0]  WBControlOut,
  output logic [4:0]  RdOut
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        AlignErr
`endif
);

  localparam int IDXW = $clog2(MEM_DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, stateNext;
  logic [7:0]        cnt, cntNext;
  logic              memRead, memWrite, req, misAlign;
  logic              capture, bubble;
  logic [IDXW-1:0]   idx;
  logic [31:0]       mem [MEM_DEPTH];

  assign memRead  = MEMControl[0];
  assign memWrite = MEMControl[1];
  assign req      = memRead | memWrite;
  assign idx      = Address[IDXW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  logic unusedAddrBits;
  assign unusedAddrBits = ^Address[31:IDXW+2];
  assign misAlign = req & (Address[1:0] != 2'b00);
`else
  logic unusedAddrBits;
  assign unusedAddrBits = ^{Address[31:IDXW+2], Address[1:0]};
  assign misAlign = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    Stall     = 1'b0;
    capture   = 1'b0;
    bubble    = 1'b0;
    case (state)
      IDLE: begin
        if (req && !misAlign && (MEM_LATENCY > 1)) begin
          Stall     = 1'b1;
          bubble    = 1'b1;
          stateNext = BUSY;
          cntNext   = 8'(MEM_LATENCY - 2);
        end else begin
          capture = 1'b1;
        end
      end
      BUSY: begin
        if (cnt != 8'd0) begin
          Stall   = 1'b1;
          bubble  = 1'b1;
          cntNext = cnt - 8'd1;
        end else begin
          capture   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    // Stall is held low while in reset so upstream never sees a phantom hold.
    if (!Rst_n) Stall = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ReadDataOut  <= '0;
      ResultOut    <= '0;
      WBControlOut <= '0;
      RdOut        <= '0;
    end else if (capture) begin
      ResultOut <= Address;
      RdOut     <= RdIn;
      if (misAlign) begin
        WBControlOut <= '0;
        ReadDataOut  <= '0;
      end else begin
        WBControlOut <= WBControl;
        ReadDataOut  <= (memRead && !memWrite) ? mem[idx] : '0;
      end
    end else if (bubble) begin
      WBControlOut <= '0;
      RdOut        <= '0;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) AlignErr <= 1'b0;
    else        AlignErr <= capture & misAlign;
  end
`endif

  // Gating with Rst_n keeps a write from landing while reset is held.
  always_ff @(posedge Clk) begin
    if (Rst_n && capture && memWrite && !misAlign)
      mem[idx] <= WriteData;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances with MEM_LATENCY 2, 4 and 3.
// Align-check scenario is built only when MEM_ALIGN_CHECK_EN is defined.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [1:0]  memc [3];
  logic [1:0]  wbc [3];
  logic [4:0]  rdin [3];
  logic        stall [3];
  logic [31:0] rdData [3];
  logic [31:0] result [3];
  logic [1:0]  wbOut [3];
  logic [4:0]  rdOut [3];
`ifdef MEM_ALIGN_CHECK_EN
  logic        alignErr [3];
`endif

  int nCompared = 0;
  int nMismatched = 0;

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 4 : 3;
    mem_stage #(.MEM_DEPTH(256), .MEM_LATENCY(LAT)) dut (
      .Clk(clk),
      .Rst_n(rst_n),
      .Address(addr[g]),
      .WriteData(wdata[g]),
      .MEMControl(memc[g]),
      .WBControl(wbc[g]),
      .RdIn(rdin[g]),
      .Stall(stall[g]),
      .ReadDataOut(rdData[g]),
      .ResultOut(result[g]),
      .WBControlOut(wbOut[g]),
      .RdOut(rdOut[g])
`ifdef MEM_ALIGN_CHECK_EN
      ,
      .AlignErr(alignErr[g])
`endif
    );
  end

  // Inputs must not move while the DUT holds Stall high.
  logic        heldStall [3];
  logic [72:0] heldIn [3];
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n && heldStall[k])
        assert ({addr[k], wdata[k], memc[k], wbc[k], rdin[k]} == heldIn[k])
          else $error("protocol violation: dut%0d inputs changed during stall", k);
      heldStall[k] <= stall[k];
      heldIn[k]    <= {addr[k], wdata[k], memc[k], wbc[k], rdin[k]};
    end
  end

  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] mc, input logic [1:0] wb, input logic [4:0] rd,
                       output int stalls, output int bubbles);
    bit done;
    done = 0;
    @(negedge clk);
    addr[k] = a; wdata[k] = wd; memc[k] = mc; wbc[k] = wb; rdin[k] = rd;
    stalls = 0; bubbles = 0;
    for (int c = 0; c < 16 && !done; c++) begin
      #1;
      if (stall[k]) begin
        stalls++;
        @(posedge clk); #1;
        if (wbOut[k] == 2'b00 && rdOut[k] == 5'd0) bubbles++;
        @(negedge clk);
      end else begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    nCompared++;
    if (!done) begin
      nMismatched++;
      $display("FAIL issue_timeout dut%0d: got %0d stall cycles without completing, required completion within 16", k, stalls);
    end
  endtask

  task automatic test_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      nCompared++;
      if ({stall[k], rdData[k], result[k], wbOut[k], rdOut[k]} !== 72'd0) begin
        nMismatched++;
        $display("FAIL reset_state dut%0d: got stall=%b rd=%h res=%h wb=%b rdo=%0d, required all 0",
                 k, stall[k], rdData[k], result[k], wbOut[k], rdOut[k]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    int s, b;
    issue(0, 32'h1234, 32'h99, 2'b00, 2'b01, 5'd5, s, b);
    nCompared++;
    if (s != 0) begin nMismatched++; $display("FAIL pass_stall: got %0d stall cycles, required 0", s); end
    nCompared++;
    if ({rdData[0], result[0], wbOut[0], rdOut[0]} !== {32'h0, 32'h1234, 2'b01, 5'd5}) begin
      nMismatched++;
      $display("FAIL pass_out: got rd=%h res=%h wb=%b rdo=%0d, required rd=0 res=1234 wb=01 rdo=5",
               rdData[0], result[0], wbOut[0], rdOut[0]);
    end
  endtask

  task automatic test_async_reset();
    #2; rst_n = 1'b0; #1;
    nCompared++;
    if ({stall[0], rdData[0], result[0], wbOut[0], rdOut[0]} !== 72'd0) begin
      nMismatched++;
      $display("FAIL async_reset: got stall=%b rd=%h res=%h wb=%b rdo=%0d, required all 0",
               stall[0], rdData[0], result[0], wbOut[0], rdOut[0]);
    end
    @(negedge clk);
    memc[0] = 2'b00; wbc[0] = 2'b00; rdin[0] = 5'd0; addr[0] = 32'h0;
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    int s, b;
    issue(0, 32'h10, 32'hDEADBEEF, 2'b10, 2'b00, 5'd3, s, b);
    nCompared++;
    if (s != 1 || b != 1) begin nMismatched++; $display("FAIL store_stall: got stalls=%0d bubbles=%0d, required 1/1", s, b); end
    nCompared++;
    if ({rdData[0], result[0], wbOut[0], rdOut[0]} !== {32'h0, 32'h10, 2'b00, 5'd3}) begin
      nMismatched++;
      $display("FAIL store_out: got rd=%h res=%h wb=%b rdo=%0d, required rd=0 res=10 wb=00 rdo=3",
               rdData[0], result[0], wbOut[0], rdOut[0]);
    end
    issue(0, 32'h10, 32'h0, 2'b01, 2'b11, 5'd8, s, b);
    nCompared++;
    if (s != 1 || b != 1) begin nMismatched++; $display("FAIL load_stall: got stalls=%0d bubbles=%0d, required 1/1", s, b); end
    nCompared++;
    if ({rdData[0], result[0], wbOut[0], rdOut[0]} !== {32'hDEADBEEF, 32'h10, 2'b11, 5'd8}) begin
      nMismatched++;
      $display("FAIL load_out: got rd=%h res=%h wb=%b rdo=%0d, required rd=deadbeef res=10 wb=11 rdo=8",
               rdData[0], result[0], wbOut[0], rdOut[0]);
    end
  endtask

  task automatic test_back_to_back();
    int s, b;
    issue(0, 32'h44, 32'hA5A50001, 2'b10, 2'b00, 5'd0, s, b);
    issue(0, 32'h44, 32'h0, 2'b01, 2'b11, 5'd2, s, b);
    nCompared++;
    if (rdData[0] !== 32'hA5A50001 || rdOut[0] !== 5'd2) begin
      nMismatched++;
      $display("FAIL b2b_load: got rd=%h rdo=%0d, required rd=a5a50001 rdo=2", rdData[0], rdOut[0]);
    end
    issue(0, 32'h410, 32'h0, 2'b01, 2'b11, 5'd4, s, b);
    nCompared++;
    if (rdData[0] !== 32'hDEADBEEF || result[0] !== 32'h410) begin
      nMismatched++;
      $display("FAIL wrap_load: got rd=%h res=%h, required rd=deadbeef res=410", rdData[0], result[0]);
    end
    issue(0, 32'h48, 32'h1111, 2'b11, 2'b01, 5'd6, s, b);
    nCompared++;
    if ({rdData[0], result[0], wbOut[0], rdOut[0]} !== {32'h0, 32'h48, 2'b01, 5'd6} || s != 1) begin
      nMismatched++;
      $display("FAIL rw_both: got rd=%h res=%h wb=%b rdo=%0d stalls=%0d, required rd=0 res=48 wb=01 rdo=6 stalls=1",
               rdData[0], result[0], wbOut[0], rdOut[0], s);
    end
    issue(0, 32'h48, 32'h0, 2'b01, 2'b11, 5'd6, s, b);
    nCompared++;
    if (rdData[0] !== 32'h1111) begin
      nMismatched++;
      $display("FAIL rw_readback: got rd=%h, required 1111", rdData[0]);
    end
    issue(0, 32'h48, 32'h0, 2'b00, 2'b01, 5'd7, s, b);
    nCompared++;
    if (rdData[0] !== 32'h0 || s != 0) begin
      nMismatched++;
      $display("FAIL nonload_clear: got rd=%h stalls=%0d, required rd=0 stalls=0", rdData[0], s);
    end
  endtask

  task automatic test_latency();
    int s, b;
    issue(1, 32'h8, 32'h77, 2'b10, 2'b00, 5'd1, s, b);
    nCompared++;
    if (s != 3) begin nMismatched++; $display("FAIL lat4_store: got %0d stall cycles, required 3", s); end
    issue(1, 32'h8, 32'h0, 2'b01, 2'b11, 5'd9, s, b);
    nCompared++;
    if (s != 3 || b != 3) begin nMismatched++; $display("FAIL lat4_stall: got stalls=%0d bubbles=%0d, required 3/3", s, b); end
    nCompared++;
    if ({rdData[1], result[1], wbOut[1], rdOut[1]} !== {32'h77, 32'h8, 2'b11, 5'd9}) begin
      nMismatched++;
      $display("FAIL lat4_load: got rd=%h res=%h wb=%b rdo=%0d, required rd=77 res=8 wb=11 rdo=9",
               rdData[1], result[1], wbOut[1], rdOut[1]);
    end
  endtask

  task automatic test_reset_mid_store();
    int s, b;
    issue(2, 32'h20, 32'h1234ABCD, 2'b10, 2'b00, 5'd0, s, b);
    nCompared++;
    if (s != 2) begin nMismatched++; $display("FAIL lat3_store: got %0d stall cycles, required 2", s); end
    @(negedge clk);
    addr[2] = 32'h20; wdata[2] = 32'h55; memc[2] = 2'b10; wbc[2] = 2'b00; rdin[2] = 5'd7;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    nCompared++;
    if ({stall[2], rdData[2], result[2], wbOut[2], rdOut[2]} !== 72'd0) begin
      nMismatched++;
      $display("FAIL mid_reset_out: got stall=%b rd=%h res=%h wb=%b rdo=%0d, required all 0",
               stall[2], rdData[2], result[2], wbOut[2], rdOut[2]);
    end
    @(negedge clk);
    memc[2] = 2'b00; addr[2] = 32'h0; wdata[2] = 32'h0; rdin[2] = 5'd0;
    @(negedge clk); rst_n = 1'b1;
    issue(2, 32'h20, 32'h0, 2'b01, 2'b11, 5'd7, s, b);
    nCompared++;
    if (rdData[2] !== 32'h1234ABCD) begin
      nMismatched++;
      $display("FAIL mid_reset_abort: got rd=%h, required 1234abcd", rdData[2]);
    end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align();
    int s, b;
    issue(0, 32'h20, 32'h600D, 2'b10, 2'b00, 5'd0, s, b);
    issue(0, 32'h22, 32'hBAD, 2'b10, 2'b01, 5'd3, s, b);
    nCompared++;
    if (s != 0 || alignErr[0] !== 1'b1 || wbOut[0] !== 2'b00 || rdData[0] !== 32'h0) begin
      nMismatched++;
      $display("FAIL align_flag: got stalls=%0d err=%b wb=%b rd=%h, required 0/1/00/0", s, alignErr[0], wbOut[0], rdData[0]);
    end
    issue(0, 32'h30, 32'h0, 2'b00, 2'b01, 5'd1, s, b);
    nCompared++;
    if (alignErr[0] !== 1'b0) begin nMismatched++; $display("FAIL align_clear: got err=%b, required 0", alignErr[0]); end
    issue(0, 32'h20, 32'h0, 2'b01, 2'b11, 5'd4, s, b);
    nCompared++;
    if (rdData[0] !== 32'h600D) begin nMismatched++; $display("FAIL align_nowrite: got rd=%h, required 600d", rdData[0]); end
  endtask
`endif

  initial begin
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; wdata[k] = '0; memc[k] = '0; wbc[k] = '0; rdin[k] = '0;
    end
    test_reset();
    test_passthrough();
    test_async_reset();
    test_store_load();
    test_back_to_back();
    test_latency();
    test_reset_mid_store();
`ifdef MEM_ALIGN_CHECK_EN
    test_align();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage, directly downstream of the EX stage.
- Consumes the ALU result, the store data, the MEM/WB control bits and the destination register.
- Performs data-memory reads and writes against an internal word-addressed RAM with configurable access latency, and stalls upstream while an access is in flight.
- Registers the results into the MEM/WB pipeline register that feeds write-back.

Parameters:
MEM_DEPTH, 256, number of 32-bit words in data memory (power of 2)
MEM_LATENCY, 2, cycles per memory access (>=1); non-memory instructions always take 1 cycle

Ports:
Clk  input  1  clock, all state updates on posedge
Rst_n  input  1  asynchronous active-low reset
Address  input  32  ALU result from EX; byte address for loads/stores
WriteData  input  32  store data from EX
MEMControl  input  2  bit0 MemRead, bit1 MemWrite
WBControl  input  2  bit0 RegWrite, bit1 MemToReg; passed through
RdIn  input  5  destination register from EX
Stall  output  1  combinational; upstream must hold all inputs stable while high
ReadDataOut  output  32  registered load data
ResultOut  output  32  registered copy of Address (ALU result)
WBControlOut  output  2  registered WBControl, or 00 for a bubble
RdOut  output  5  registered destination register

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values: ReadDataOut=0, ResultOut=0, WBControlOut=00, RdOut=0, FSM=IDLE, counter=0.
- Memory contents are not reset.
- Addressing: word index = Address[log2(MEM_DEPTH)+1:2]. Higher bits are ignored (wrap modulo depth). Address[1:0] is ignored unless the optional feature is enabled.
- Request: req = MemRead | MemWrite.
- FSM states: IDLE, BUSY; 8-bit down-counter cnt.
- IDLE, req=0 or MEM_LATENCY=1:
  - Stall=0.
  - At posedge, capture outputs: ResultOut<=Address, WBControlOut<=WBControl, RdOut<=RdIn.
  - Read: ReadDataOut<=mem[idx]. Write: mem[idx]<=WriteData.
- IDLE, req=1 and MEM_LATENCY>1:
  - Stall=1.
  - Next state BUSY, cnt<=MEM_LATENCY-2.
  - Output register loads a bubble: WBControlOut<=00, RdOut<=0, ReadDataOut and ResultOut hold.
- BUSY, cnt!=0: Stall=1, cnt<=cnt-1, bubble as above.
- BUSY, cnt==0:
  - Stall=0.
  - Capture outputs and perform the memory access exactly as in the IDLE/no-stall case.
  - Next state IDLE.
- Latency: a memory access occupies exactly MEM_LATENCY cycles, and Stall is high for MEM_LATENCY-1 of them. The write commits only on the final edge.
- Non-load instructions: when MemRead=0, ReadDataOut<=0 at capture.
- MemRead=MemWrite=1: treated as a write; ReadDataOut<=0.
- Back-to-back accesses:
  - The next instruction is sampled on the cycle after capture.
  - A load immediately after a store to the same word returns the new data.
- Reset mid-BUSY: FSM returns to IDLE, the pending write is aborted (memory unchanged), and outputs take their reset values.
- Input changes while Stall=1 are a protocol violation; behaviour is undefined and a bench assertion flags it.

Optional Feature:
Macro: MEM_ALIGN_CHECK_EN
- Defined:
  - Adds output port AlignErr (1 bit, registered, reset 0).
  - A request with Address[1:0]!=00 is suppressed: no write, ReadDataOut<=0, WBControlOut<=00, and no stall cycles.
  - AlignErr<=1 for exactly one cycle at capture. AlignErr<=0 on every other capture.
- Undefined:
  - AlignErr port is absent.
  - Address[1:0] is ignored and misaligned accesses behave as aligned.

Test Plan:
- Reset: assert Rst_n=0 mid-cycle -> all outputs 0 immediately (asynchronous), Stall=0.
- ALU passthrough, MEM_LATENCY=2: Address=0x1234, MEMControl=00, WBControl=01, RdIn=5 -> next edge ResultOut=0x1234, WBControlOut=01, RdOut=5, ReadDataOut=0, Stall never high.
- Store then load, MEM_LATENCY=2:
  - Store 0xDEADBEEF to 0x10 -> Stall high for 1 cycle, WBControlOut=00 during the stall.
  - Load 0x10 with WBControl=11, RdIn=8 -> Stall 1 cycle, then ReadDataOut=0xDEADBEEF, RdOut=8.
- Latency sweep with MEM_LATENCY=4: load -> Stall high exactly 3 consecutive cycles, output valid on the 4th edge, 3 bubbles emitted.
- Reset mid-store: store 0x55 to 0x20 (MEM_LATENCY=3), deassert Rst_n during the 2nd cycle, release, then load 0x20 -> previous contents returned, not 0x55.
- MEM_ALIGN_CHECK_EN defined: store to 0x22 -> AlignErr=1 for one cycle, no stall; then a load from 0x20 shows the word unchanged.
